// File: rtl/serial_frame_pkg.sv
// serial_frame_pkg: shared FSM state encoding and frame geometry for the serial receiver.
package serial_frame_pkg;
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
   localparam int DATA_W_DEF = 8;
   localparam int FRAME_BITS = DATA_W_DEF + 3;
endpackage

// File: rtl/serial_frame_rx_sync_ff.sv
// sync_ff: multi-flop synchroniser; resets to the idle-high line level.
module sync_ff #(
   parameter int ST = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q
);
   logic [ST-1:0] r_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_q <= '1;
      else        r_q <= {r_q[ST-2:0], i_d};
   assign o_q = r_q[ST-1];
endmodule

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: start-bit detect, LSB-first deserialise, even-parity/stop check,
// one-word holding register on a valid/ready output with error and overrun pulses.
module serial_frame_rx
   import serial_frame_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int SYNC_ST = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ser_in,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              frame_err,
   output logic              overrun
);
   localparam int CW = $clog2(DATA_W) + 1;
   logic              w_s;
   logic [DATA_W:0]   w_cat;
   logic              w_room;
   state_t            r_state;
   logic [CW-1:0]     r_bit_cnt;
   logic [DATA_W-1:0] r_shift;
   logic              r_par_ok;
   sync_ff #(.ST(SYNC_ST)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (ser_in),
      .o_q   (w_s)
   );
   // Shifting through a one-bit-wider vector keeps DATA_W=1 legal; its XOR is data^parity.
   assign w_cat  = {w_s, r_shift};
   assign w_room = !out_valid || out_ready;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_par_ok  <= 1'b0;
         out_data  <= '0;
         out_valid <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         if (out_valid && out_ready) out_valid <= 1'b0;
         case (r_state)
            IDLE: if (!w_s) begin
               r_state   <= DATA;
               r_bit_cnt <= '0;
            end
            DATA: begin
               r_shift   <= w_cat[DATA_W:1];
               r_bit_cnt <= r_bit_cnt + 1'b1;
               if (r_bit_cnt == CW'(DATA_W - 1)) r_state <= PARITY;
            end
            PARITY: begin
               r_par_ok <= ~(^w_cat);
               r_state  <= STOP;
            end
            STOP: begin
               r_state <= IDLE;
               if (!(w_s && r_par_ok)) frame_err <= 1'b1;
               else if (w_room) begin
                  out_data  <= r_shift;
                  out_valid <= 1'b1;
               end else overrun <= 1'b1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx: directed frames with hand-computed words, parity and timing.
module tb_serial_frame_rx;
   import serial_frame_pkg::*;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ser_in = 1'b1;
   logic       out_ready = 1'b0;
   logic [7:0] out_data;
   logic       out_valid, frame_err, overrun;
   int n_cmp = 0, n_bad = 0;
   int cyc = 0, n_ferr = 0, n_ovr = 0, n_vld = 0, n_both = 0, ferr_cyc = -1, ovr_cyc = -1;
   logic [7:0] acc_d[$];
   int         acc_c[$];

   serial_frame_rx #(.DATA_W(8), .SYNC_ST(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ser_in    (ser_in),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         acc_d.push_back(out_data);
         acc_c.push_back(cyc);
      end
      if (frame_err) begin n_ferr++; ferr_cyc = cyc; end
      if (overrun) begin n_ovr++; ovr_cyc = cyc; end
      if (out_valid) n_vld++;
      if (frame_err && overrun) n_both++;
   end

   task automatic drive_bit(input logic b);
      @(posedge clk);
      #1 ser_in = b;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic p, input logic st, output int t0);
      drive_bit(1'b0);
      t0 = cyc;
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      drive_bit(p);
      drive_bit(st);
   endtask

   task automatic idle(input int n);
      repeat (n) drive_bit(1'b1);
   endtask

   task automatic test_reset;
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
      n_cmp++; if (out_data !== 8'h00) begin n_bad++; $display("FAIL reset_data got %h want 00", out_data); end
      n_cmp++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin n_bad++; $display("FAIL reset_pulses got %b%b want 00", frame_err, overrun); end
      n_cmp++; if (dut.r_state !== IDLE) begin n_bad++; $display("FAIL reset_state got %0d want IDLE", dut.r_state); end
   endtask

   task automatic test_good;
      int t0, k, v, fe;
      out_ready = 1'b1;
      k = acc_d.size(); v = n_vld; fe = n_ferr;
      send_frame(8'hA5, 1'b0, 1'b1, t0);
      idle(6);
      n_cmp++; if (acc_d.size() - k !== 1) begin n_bad++; $display("FAIL good_count got %0d want 1", acc_d.size() - k); end
      if (acc_d.size() > k) begin
         n_cmp++; if (acc_d[k] !== 8'hA5) begin n_bad++; $display("FAIL good_data got %h want a5", acc_d[k]); end
         n_cmp++; if (acc_c[k] !== t0 + 13) begin n_bad++; $display("FAIL good_latency got %0d want %0d", acc_c[k], t0 + 13); end
      end
      n_cmp++; if (n_vld - v !== 1) begin n_bad++; $display("FAIL good_valid_cycles got %0d want 1", n_vld - v); end
      n_cmp++; if (n_ferr - fe !== 0) begin n_bad++; $display("FAIL good_ferr got %0d want 0", n_ferr - fe); end
   endtask

   task automatic test_parity_err;
      int t0, k, fe;
      k = acc_d.size(); fe = n_ferr;
      send_frame(8'h3C, 1'b1, 1'b1, t0);
      idle(6);
      n_cmp++; if (n_ferr - fe !== 1) begin n_bad++; $display("FAIL par_ferr_count got %0d want 1", n_ferr - fe); end
      n_cmp++; if (ferr_cyc !== t0 + 13) begin n_bad++; $display("FAIL par_ferr_cycle got %0d want %0d", ferr_cyc, t0 + 13); end
      n_cmp++; if (acc_d.size() - k !== 0) begin n_bad++; $display("FAIL par_accepts got %0d want 0", acc_d.size() - k); end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL par_valid got %b want 0", out_valid); end
      n_cmp++; if (out_data !== 8'hA5) begin n_bad++; $display("FAIL par_data_kept got %h want a5", out_data); end
   endtask

   task automatic test_stop_err;
      int t0, k, fe;
      k = acc_d.size(); fe = n_ferr;
      send_frame(8'h81, 1'b0, 1'b0, t0);
      idle(1);
      send_frame(8'h01, 1'b1, 1'b1, t0);
      idle(6);
      n_cmp++; if (n_ferr - fe !== 1) begin n_bad++; $display("FAIL stop_ferr_count got %0d want 1", n_ferr - fe); end
      n_cmp++; if (acc_d.size() - k !== 1) begin n_bad++; $display("FAIL stop_recover_count got %0d want 1", acc_d.size() - k); end
      if (acc_d.size() > k) begin
         n_cmp++; if (acc_d[k] !== 8'h01) begin n_bad++; $display("FAIL stop_recover_data got %h want 01", acc_d[k]); end
      end
   endtask

   task automatic test_overrun;
      int t1, t2, k, ov, fe;
      out_ready = 1'b0;
      k = acc_d.size(); ov = n_ovr; fe = n_ferr;
      send_frame(8'h11, 1'b0, 1'b1, t1);
      send_frame(8'h22, 1'b0, 1'b1, t2);
      idle(6);
      n_cmp++; if (n_ovr - ov !== 1) begin n_bad++; $display("FAIL ovr_count got %0d want 1", n_ovr - ov); end
      n_cmp++; if (ovr_cyc !== t2 + 13) begin n_bad++; $display("FAIL ovr_cycle got %0d want %0d", ovr_cyc, t2 + 13); end
      n_cmp++; if (n_ferr - fe !== 0) begin n_bad++; $display("FAIL ovr_ferr got %0d want 0", n_ferr - fe); end
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h11) begin n_bad++; $display("FAIL ovr_held got v=%b d=%h want v=1 d=11", out_valid, out_data); end
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_cmp++; if (acc_d.size() - k !== 1) begin n_bad++; $display("FAIL ovr_drain_count got %0d want 1", acc_d.size() - k); end
      if (acc_d.size() > k) begin
         n_cmp++; if (acc_d[k] !== 8'h11) begin n_bad++; $display("FAIL ovr_drain_data got %h want 11", acc_d[k]); end
      end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ovr_valid_drop got %b want 0", out_valid); end
   endtask

   task automatic test_back_to_back;
      logic [7:0] w [4];
      int t0, tx, k, fe, ov;
      w[0] = 8'h00; w[1] = 8'hFF; w[2] = 8'h55; w[3] = 8'hAA;
      out_ready = 1'b1;
      k = acc_d.size(); fe = n_ferr; ov = n_ovr;
      send_frame(w[0], 1'b0, 1'b1, t0);
      for (int i = 1; i < 4; i++) send_frame(w[i], ^w[i], 1'b1, tx);
      idle(6);
      n_cmp++; if (acc_d.size() - k !== 4) begin n_bad++; $display("FAIL b2b_count got %0d want 4", acc_d.size() - k); end
      for (int i = 0; i < 4 && k + i < acc_d.size(); i++) begin
         n_cmp++; if (acc_d[k+i] !== w[i]) begin n_bad++; $display("FAIL b2b_data[%0d] got %h want %h", i, acc_d[k+i], w[i]); end
         n_cmp++; if (acc_c[k+i] !== t0 + 13 + FRAME_BITS * i) begin n_bad++; $display("FAIL b2b_cycle[%0d] got %0d want %0d", i, acc_c[k+i], t0 + 13 + FRAME_BITS * i); end
      end
      n_cmp++; if (n_ferr - fe !== 0 || n_ovr - ov !== 0) begin n_bad++; $display("FAIL b2b_errors got ferr=%0d ovr=%0d want 0 0", n_ferr - fe, n_ovr - ov); end
   endtask

   task automatic test_reset_mid;
      int t0, k, fe, ov;
      out_ready = 1'b0;
      send_frame(8'h5A, 1'b0, 1'b1, t0);
      idle(4);
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h5A) begin n_bad++; $display("FAIL rst_pre got v=%b d=%h want v=1 d=5a", out_valid, out_data); end
      drive_bit(1'b0);
      for (int i = 0; i < 5; i++) drive_bit(i[0]);
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin n_bad++; $display("FAIL rst_mid_out got v=%b d=%h want v=0 d=00", out_valid, out_data); end
      n_cmp++; if (dut.r_state !== IDLE || dut.r_bit_cnt !== '0) begin n_bad++; $display("FAIL rst_mid_fsm got st=%0d cnt=%0d want IDLE 0", dut.r_state, dut.r_bit_cnt); end
      for (int i = 0; i < 4; i++) drive_bit(i[0]);
      ser_in = 1'b1;
      fe = n_ferr; ov = n_ovr;
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++; if (n_ferr - fe !== 0 || n_ovr - ov !== 0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_release got ferr=%0d ovr=%0d v=%b want 0 0 0", n_ferr - fe, n_ovr - ov, out_valid); end
      out_ready = 1'b1;
      k = acc_d.size();
      send_frame(8'h3C, 1'b0, 1'b1, t0);
      idle(6);
      n_cmp++; if (acc_d.size() - k !== 1 || (acc_d.size() > k && acc_d[k] !== 8'h3C)) begin n_bad++; $display("FAIL rst_recover got n=%0d want one word 3c", acc_d.size() - k); end
      n_cmp++; if (n_both !== 0) begin n_bad++; $display("FAIL err_and_ovr_together got %0d want 0", n_both); end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      test_reset;
      test_good;
      test_parity_err;
      test_stop_err;
      test_overrun;
      test_back_to_back;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
